// File: rtl/mdr_mem_interface.sv
// Memory Data Register with a req/ack memory handshake controller.
// Runs one read or write transaction at a time, with wait states and a timeout abort.
module mdr_mem_interface #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MDRin,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MAR_q,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mdr;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_done;
    logic               r_err;
    logic               w_start_rd;
    logic               w_start_wr;
    logic               w_ack_ok;
    logic               w_abort;

    always_ff @(posedge clock) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Read has priority over write when both strobes arrive together.
    always_comb begin
        w_next     = r_state;
        w_start_rd = 1'b0;
        w_start_wr = 1'b0;
        w_ack_ok   = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (MemRead) begin
                    w_start_rd = 1'b1;
                    w_next     = RD_WAIT;
                end else if (MemWrite) begin
                    w_start_wr = 1'b1;
                    w_next     = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack) begin
                    w_ack_ok = 1'b1;
                    w_next   = IDLE;
                end else if (r_cnt == CNT_LIMIT) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (r_state != IDLE && !mem_ack && !w_abort) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_mdr   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_ack_ok;
            if (r_state == IDLE && MDRin)
                r_mdr <= BusMuxOut;
            else if (r_state == RD_WAIT && mem_ack)
                r_mdr <= mem_rdata;
            if (w_start_rd || w_start_wr)
                r_addr <= MAR_q;
            // A same-cycle bus load is what gets written, not the stale MDR.
            if (w_start_wr)
                r_wdata <= MDRin ? BusMuxOut : r_mdr;
            if (w_start_rd || w_start_wr)
                r_err <= 1'b0;
            else if (w_abort)
                r_err <= 1'b1;
        end
    end

    assign BusMuxInMDR = r_mdr;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_rd_req  = (r_state == RD_WAIT);
    assign mem_wr_req  = (r_state == WR_WAIT);
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Bench for mdr_mem_interface: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_mdr_mem_interface;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          clear;
    logic [DW-1:0] BusMuxOut;
    logic          MDRin;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] MAR_q;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [DW-1:0] BusMuxInMDR;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic          busy;
    logic          done;
    logic          timeout_err;

    always #5 clock = ~clock;

    mdr_mem_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MDRin(MDRin),
        .MemRead(MemRead), .MemWrite(MemWrite), .MAR_q(MAR_q),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .BusMuxInMDR(BusMuxInMDR),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_req(mem_rd_req),
        .mem_wr_req(mem_wr_req), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: kind 0 = no transaction, 1 = read pending, 2 = write pending.
    // age = number of wait cycles already elapsed without an ack.
    logic [DW-1:0] m_mdr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_done;
    logic          m_err;
    int            m_kind;
    int            m_age;

    task automatic model_edge();
        if (clear) begin
            m_mdr = '0; m_addr = '0; m_wdata = '0; m_done = 0; m_err = 0;
            m_kind = 0; m_age = 0;
        end else if (m_kind == 0) begin
            m_done = 0;
            if (MemRead || MemWrite) begin
                m_kind  = MemRead ? 1 : 2;
                m_age   = 0;
                m_addr  = MAR_q;
                m_err   = 0;
                if (!MemRead) m_wdata = MDRin ? BusMuxOut : m_mdr;
            end
            if (MDRin) m_mdr = BusMuxOut;
        end else begin
            m_done = 0;
            if (mem_ack) begin
                if (m_kind == 1) m_mdr = mem_rdata;
                m_done = 1;
                m_kind = 0;
            end else if (m_age + 1 == TO) begin
                m_err  = 1;
                m_kind = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check("mdr",   BusMuxInMDR, m_mdr);
        check("addr",  mem_addr,    m_addr);
        check("wdata", mem_wdata,   m_wdata);
        check("rdreq", mem_rd_req,  m_kind == 1);
        check("wrreq", mem_wr_req,  m_kind == 2);
        check("busy",  busy,        m_kind != 0);
        check("done",  done,        m_done);
        check("terr",  timeout_err, m_err);
    endtask

    task automatic quiet();
        clear = 0; MDRin = 0; MemRead = 0; MemWrite = 0; mem_ack = 0;
    endtask

    int cnt;
    int saw_done;
    int pct;

    initial begin
        quiet();
        BusMuxOut = '0; MAR_q = '0; mem_rdata = '0;
        m_mdr = '0; m_addr = '0; m_wdata = '0; m_done = 0; m_err = 0;
        m_kind = 0; m_age = 0;

        clear = 1; tick(); tick(); clear = 0;
        check("rst_mdr", BusMuxInMDR, 0);
        check("rst_busy", busy, 0);

        MDRin = 1; BusMuxOut = 32'hDEADBEEF; tick(); MDRin = 0;
        check("load_mdr", BusMuxInMDR, 32'hDEADBEEF);
        check("load_busy", busy, 0);

        MemRead = 1; MAR_q = 9'h012; tick(); MemRead = 0;
        cnt = 0;
        repeat (3) begin
            if (mem_rd_req) cnt++;
            tick();
        end
        if (mem_rd_req) cnt++;
        mem_ack = 1; mem_rdata = 32'h12345678; tick(); mem_ack = 0;
        check("rd_req_len", cnt, 4);
        check("rd_mdr", BusMuxInMDR, 32'h12345678);
        check("rd_addr", mem_addr, 9'h012);
        check("rd_done", done, 1);
        tick();
        check("rd_done_pulse", done, 0);

        MDRin = 1; BusMuxOut = 32'hA5A5A5A5; tick();
        MemWrite = 1; BusMuxOut = 32'h0000FFFF; tick(); MDRin = 0; MemWrite = 0;
        check("wr_wdata", mem_wdata, 32'h0000FFFF);
        check("wr_mdr", BusMuxInMDR, 32'h0000FFFF);
        mem_ack = 1; tick(); mem_ack = 0;
        check("wr_done", done, 1);
        tick();
        check("wr_done_pulse", done, 0);

        MemRead = 1; MAR_q = 9'h1F0; tick(); MemRead = 0;
        cnt = 0; saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_rd_req) break;
            cnt++;
            tick();
            if (done) saw_done = 1;
        end
        check("to_req_len", cnt, TO);
        check("to_err", timeout_err, 1);
        check("to_mdr", BusMuxInMDR, 32'h0000FFFF);
        check("to_no_done", saw_done, 0);
        MemRead = 1; tick(); MemRead = 0;
        check("to_err_clr", timeout_err, 0);
        mem_ack = 1; mem_rdata = 32'h0BADF00D; tick(); mem_ack = 0;

        MemRead = 1; MemWrite = 1; MAR_q = 9'h055; tick(); MemRead = 0; MemWrite = 0;
        check("both_rd", mem_rd_req, 1);
        check("both_wr", mem_wr_req, 0);
        MemWrite = 1; MDRin = 1; BusMuxOut = 32'h00000BAD; tick(); MemWrite = 0; MDRin = 0;
        check("busy_ign_mdr", BusMuxInMDR, 32'h0BADF00D);
        mem_ack = 1; mem_rdata = 32'hCAFE0001; tick(); mem_ack = 0;
        check("both_mdr", BusMuxInMDR, 32'hCAFE0001);
        tick();
        check("both_no_wr", mem_wr_req, 0);

        MemRead = 1; MAR_q = 9'h0AA; tick(); MemRead = 0;
        tick(); tick();
        clear = 1; tick(); clear = 0;
        check("clr_req", mem_rd_req, 0);
        check("clr_busy", busy, 0);
        check("clr_mdr", BusMuxInMDR, 0);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF; tick(); mem_ack = 0;
        check("late_ack_mdr", BusMuxInMDR, 0);
        check("late_ack_done", done, 0);

        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg == 0) ? 0 : (seg == 1) ? 3 : (seg == 2) ? 15 : (seg == 3) ? 40 : (seg == 4) ? 80 : 100;
            repeat (500) begin
                clear     = ($urandom % 150) == 0;
                MDRin     = ($urandom % 4) == 0;
                MemRead   = ($urandom % 6) == 0;
                MemWrite  = ($urandom % 6) == 0;
                MAR_q     = AW'($urandom);
                BusMuxOut = $urandom;
                mem_rdata = $urandom;
                mem_ack   = int'($urandom % 100) < pct;
                tick();
            end
        end
        quiet();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
